quick_spi_slave: RTL and testbench

QUICK_SPI_SLAVE -- requirements
Module: quick_spi_slave

---
 rtl/quick_spi_pkg.sv | 20 ++
 rtl/quick_spi_sync.sv | 34 +++
 rtl/quick_spi_slave.sv | 145 ++++++++++++++
 tb/tb_quick_spi_slave.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/quick_spi_pkg.sv
// Shared definitions for the quick_spi_slave SPI mode-0 slave: word width,
// bit-counter width, FSM state encoding and the default synchronizer depth.
package quick_spi_pkg;

   localparam int WORD_W          = 8;
   localparam int CNT_W           = 3;
   localparam int DEF_SYNC_STAGES = 2;

   localparam int          STATE_W  = 1;
   localparam logic [0:0]  ST_IDLE  = 1'b0;
   localparam logic [0:0]  ST_SHIFT = 1'b1;

   typedef logic [WORD_W-1:0] word_t;

   // Shift a word left by one, inserting the new bit at the LSB.
   function automatic word_t shiftIn(input word_t w, input logic b);
      return {w[WORD_W-2:0], b};
   endfunction

endpackage

// File: rtl/quick_spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses
// derived from the last two synchronized samples.
module quick_spi_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_chain;
   logic              r_prev;

   // Reset both the chain and the previous sample to the idle level so that
   // reset release never produces a spurious edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_chain <= {STAGES{RESET_VAL}};
         r_prev  <= RESET_VAL;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_async};
         r_prev  <= r_chain[STAGES-1];
      end
   end

   assign o_sync = r_chain[STAGES-1];
   assign o_rise =  o_sync & ~r_prev;
   assign o_fall = ~o_sync &  r_prev;

endmodule

// File: rtl/quick_spi_slave.sv
// SPI mode-0 slave (8-bit, MSB first) oversampling sck/cs_n/mosi in clk.
// Define QUICK_SPI_SLAVE_STATUS_EN to add tx_underrun / frame_abort pulses.
module quick_spi_slave
   import quick_spi_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sck,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [WORD_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy
`ifdef QUICK_SPI_SLAVE_STATUS_EN
   ,
   output logic              tx_underrun,
   output logic              frame_abort
`endif
);

   logic w_sck_lvl, w_sck_rise, w_sck_fall;
   logic w_cs_lvl, w_cs_rise, w_cs_fall;
   logic w_mosi, w_mosi_rise, w_mosi_fall;

   quick_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
      .clk(clk), .rst(rst), .i_async(sck),
      .o_sync(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
   );

   quick_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst(rst), .i_async(cs_n),
      .o_sync(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
   );

   quick_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .i_async(mosi),
      .o_sync(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
   );

   logic w_unused_sync;
   assign w_unused_sync = &{1'b0, w_sck_lvl, w_cs_lvl, w_mosi_rise, w_mosi_fall};

   logic [STATE_W-1:0] r_state;
   logic [CNT_W-1:0]   r_bit_cnt;
   word_t              r_tx_shift;
   word_t              r_rx_shift;
   word_t              r_hold;
   logic               r_hold_full;
   word_t              r_rx_data;
   logic               r_rx_valid;

   logic  w_in_shift, w_start, w_stop, w_rx_edge, w_tx_edge, w_load, w_write;
   word_t w_rx_next;

   // A cs_n rise wins over a coincident sck edge, so a frame that ends on its
   // final falling edge does not pull another byte out of the holding register.
   assign w_in_shift = (r_state == ST_SHIFT);
   assign w_start    = (r_state == ST_IDLE) & w_cs_fall;
   assign w_stop     = w_in_shift & w_cs_rise;
   assign w_rx_edge  = w_in_shift & ~w_cs_rise & w_sck_rise;
   assign w_tx_edge  = w_in_shift & ~w_cs_rise & w_sck_fall;
   assign w_load     = w_start | (w_tx_edge & (r_bit_cnt == '0));
   assign w_write    = tx_valid & ~r_hold_full;
   assign w_rx_next  = shiftIn(r_rx_shift, w_mosi);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= '0;
         r_rx_shift <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (w_start) begin
            r_state   <= ST_SHIFT;
            r_bit_cnt <= '0;
         end else if (w_stop) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
         end else if (w_rx_edge) begin
            r_rx_shift <= w_rx_next;
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == '1) begin
               r_rx_data  <= w_rx_next;
               r_rx_valid <= 1'b1;
            end
         end
      end
   end

   // Load-then-fill: a load consumes the old holding content first, then a
   // same-cycle write refills the holding register with the new byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_shift  <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else begin
         if (w_load) begin
            r_tx_shift  <= r_hold_full ? r_hold : '0;
            r_hold_full <= 1'b0;
         end else if (w_tx_edge) begin
            r_tx_shift <= shiftIn(r_tx_shift, 1'b0);
         end
         if (w_write) begin
            r_hold      <= tx_data;
            r_hold_full <= 1'b1;
         end
      end
   end

`ifdef QUICK_SPI_SLAVE_STATUS_EN
   logic r_tx_underrun, r_frame_abort;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_underrun <= 1'b0;
         r_frame_abort <= 1'b0;
      end else begin
         r_tx_underrun <= w_load & ~r_hold_full;
         r_frame_abort <= w_stop & (r_bit_cnt != '0);
      end
   end

   assign tx_underrun = r_tx_underrun;
   assign frame_abort = r_frame_abort;
`endif

   assign miso     = w_in_shift & r_tx_shift[WORD_W-1];
   assign miso_oe  = w_in_shift;
   assign busy     = w_in_shift;
   assign tx_ready = ~r_hold_full;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_quick_spi_slave.sv
// Self-checking bench for quick_spi_slave: a clk/8 mode-0 master model,
// table-driven single-byte frames, hand-written corner sequences and an rx scoreboard.
module tb_quick_spi_slave;

   logic       clk = 1'b0;
   logic       rst;
   logic       sck;
   logic       csN;
   logic       mosi;
   logic       miso;
   logic       misoOe;
   logic [7:0] txData;
   logic       txValid;
   logic       txReady;
   logic [7:0] rxData;
   logic       rxValid;
   logic       busy;
`ifdef QUICK_SPI_SLAVE_STATUS_EN
   logic       txUnderrun;
   logic       frameAbort;
   int         underrunCount = 0;
   int         abortCount = 0;
`endif

   int checks = 0;
   int failures = 0;
   int rxCount = 0;
   int expectedRx = 0;
   logic [7:0] expQ[$];

   typedef struct {
      logic       preload;
      logic [7:0] txByte;
      logic [7:0] mosiByte;
      logic [7:0] expMiso;
      logic [7:0] expRx;
   } vector_t;

   vector_t    vectors[4];
   logic [7:0] gotA;
   logic [7:0] gotB;

   quick_spi_slave dut (
      .clk(clk),
      .rst(rst),
      .sck(sck),
      .cs_n(csN),
      .mosi(mosi),
      .miso(miso),
      .miso_oe(misoOe),
      .tx_data(txData),
      .tx_valid(txValid),
      .tx_ready(txReady),
      .rx_data(rxData),
      .rx_valid(rxValid),
      .busy(busy)
`ifdef QUICK_SPI_SLAVE_STATUS_EN
      ,
      .tx_underrun(txUnderrun),
      .frame_abort(frameAbort)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   // Scoreboard: every rx_valid pulse pops one expected byte.
   always @(negedge clk) begin : monitor
      logic [7:0] expByte;
      if (!rst && rxValid) begin
         rxCount++;
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL rx_unexpected: got rx_valid with %0h, required no pulse", rxData);
         end else begin
            expByte = expQ.pop_front();
            checkOutput("rx_scoreboard", {24'd0, rxData}, {24'd0, expByte});
         end
      end
`ifdef QUICK_SPI_SLAVE_STATUS_EN
      if (!rst && txUnderrun) underrunCount++;
      if (!rst && frameAbort) abortCount++;
`endif
   end

   task automatic writeTx(input logic [7:0] b);
      bit done;
      done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (txReady) begin
            txData  = b;
            txValid = 1'b1;
            @(negedge clk);
            txValid = 1'b0;
            done    = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("[TB] FAIL tx_write_timeout: tx_ready=0, required 1");
      end
   endtask

   task automatic startFrame();
      @(negedge clk);
      csN = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   // Master shifts nBits; with endFrame the last sck fall and cs_n rise coincide.
   task automatic xferBits(input logic [7:0] mo, input int nBits, input bit endFrame,
                           output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nBits; i++) begin
         mosi = mo[7-i];
         repeat (4) @(negedge clk);
         sck = 1'b1;
         mi[7-i] = miso;
         repeat (4) @(negedge clk);
         sck = 1'b0;
         if (endFrame && i == nBits - 1) csN = 1'b1;
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_miso"},     {31'd0, miso},    32'd0);
      checkOutput({tag, "_miso_oe"},  {31'd0, misoOe},  32'd0);
      checkOutput({tag, "_tx_ready"}, {31'd0, txReady}, 32'd1);
      checkOutput({tag, "_rx_data"},  {24'd0, rxData},  32'd0);
      checkOutput({tag, "_rx_valid"}, {31'd0, rxValid}, 32'd0);
      checkOutput({tag, "_busy"},     {31'd0, busy},    32'd0);
   endtask

   task automatic applyStimulus(input vector_t v);
      logic [7:0] got;
`ifdef QUICK_SPI_SLAVE_STATUS_EN
      int urBefore;
`endif
      if (v.preload) begin
         writeTx(v.txByte);
         checkOutput("tx_ready_full", {31'd0, txReady}, 32'd0);
      end
`ifdef QUICK_SPI_SLAVE_STATUS_EN
      urBefore = underrunCount;
`endif
      expQ.push_back(v.expRx);
      expectedRx++;
      startFrame();
      checkOutput("busy_in_frame", {31'd0, busy}, 32'd1);
      checkOutput("miso_oe_in_frame", {31'd0, misoOe}, 32'd1);
      xferBits(v.mosiByte, 8, 1'b1, got);
      repeat (10) @(negedge clk);
      checkOutput("miso_byte", {24'd0, got}, {24'd0, v.expMiso});
      checkOutput("rx_data", {24'd0, rxData}, {24'd0, v.expRx});
      checkOutput("busy_after", {31'd0, busy}, 32'd0);
      checkOutput("tx_ready_after", {31'd0, txReady}, 32'd1);
`ifdef QUICK_SPI_SLAVE_STATUS_EN
      checkOutput("tx_underrun_count", underrunCount - urBefore, v.preload ? 32'd0 : 32'd1);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectors[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
      vectors[1] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};
      vectors[2] = '{1'b1, 8'h0F, 8'hF0, 8'h0F, 8'hF0};
      vectors[3] = '{1'b1, 8'h81, 8'h55, 8'h81, 8'h55};

      rst = 1'b1; csN = 1'b1; sck = 1'b0; mosi = 1'b0;
      txValid = 1'b0; txData = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkResetOutputs("reset");

      for (int i = 0; i < 4; i++) applyStimulus(vectors[i]);

      // Two bytes in one frame; second tx byte written while the first shifts.
      writeTx(8'hC3);
      expQ.push_back(8'h01);
      expQ.push_back(8'h80);
      expectedRx += 2;
      startFrame();
      fork
         begin
            xferBits(8'h01, 8, 1'b0, gotA);
            xferBits(8'h80, 8, 1'b1, gotB);
         end
         begin
            repeat (20) @(negedge clk);
            writeTx(8'h5A);
         end
      join
      repeat (10) @(negedge clk);
      checkOutput("b2b_miso_first", {24'd0, gotA}, 32'hC3);
      checkOutput("b2b_miso_second", {24'd0, gotB}, 32'h5A);
      checkOutput("b2b_tx_ready", {31'd0, txReady}, 32'd1);

      // Deselect after 5 bits: partial byte dropped, then a clean frame.
      startFrame();
      xferBits(8'hB6, 5, 1'b0, gotA);
      repeat (4) @(negedge clk);
      csN = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_miso_oe", {31'd0, misoOe}, 32'd0);
`ifdef QUICK_SPI_SLAVE_STATUS_EN
      checkOutput("abort_pulses", abortCount, 32'd1);
`endif
      applyStimulus('{1'b1, 8'h99, 8'h66, 8'h99, 8'h66});

      // Reset pulse mid-byte with the holding register full.
      writeTx(8'h77);
      startFrame();
      writeTx(8'hE1);
      checkOutput("pre_reset_tx_ready", {31'd0, txReady}, 32'd0);
      xferBits(8'hC9, 3, 1'b0, gotA);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      csN = 1'b1;
      checkResetOutputs("midreset");
      repeat (10) @(negedge clk);
      checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);

      repeat (20) @(negedge clk);
      checkOutput("rx_count", rxCount, expectedRx);
      checkOutput("scoreboard_empty", expQ.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
